clint: RTL and testbench
========================

CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter: DATA_SIZE, 32, bus data width in bits; the only legal values are 32 and 64.
REQ-002 Parameter: CLOCK_CYCLES, 1, clock cycles per mtime increment; must be at least 1.
REQ-003 Port: clock, input, 1, the only clock; all state updates on its rising edge.
REQ-004 Port: reset, input, 1, asynchronous active-high reset.
REQ-005 Port: CYC_I, input, 1, Wishbone cycle.
REQ-006 Port: STB_I, input, 1, Wishbone strobe.
REQ-007 Port: WE_I, input, 1, write enable.
REQ-008 Port: ADR_I, input, 16, byte offset within the CLINT window.
REQ-009 Port: SEL_I, input, DATA_SIZE/8, byte lane enables.
REQ-010 Port: DAT_I, input, DATA_SIZE, write data.
REQ-011 Port: DAT_O, output, DATA_SIZE, registered read data.
REQ-012 Port: ACK_O, output, 1, registered acknowledge.
REQ-013 Port: msip, output, DATA_SIZE, software interrupt pending; bit 0 is live and all other bits are 0; drives the core mem_msip.
REQ-014 Port: mtime, output, 64, timer value; drives the core mem_mtime.
REQ-015 Port: mtimecmp, output, 64, timer compare value; drives the core mem_mtimecmp.

Function
REQ-016 The bus FSM SHALL have two states, IDLE and ACK. IDLE goes to ACK when CYC_I&STB_I=1. ACK goes to IDLE unconditionally.
- ACK_O=1 only in the ACK state, so it is high for exactly one cycle per access.
- Latency from strobe to ACK_O is 1 cycle.
- The minimum spacing between accepted accesses is 2 cycles.
REQ-017 Access sampling:
- The address, data, SEL_I and WE_I SHALL be sampled on the IDLE->ACK edge.
- A write SHALL take effect on that same edge.
- For a read, DAT_O SHALL be loaded on that edge and held until the next accepted read.
REQ-018 Register map, DATA_SIZE=32: 0x0000 msip; 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-019 Register map, DATA_SIZE=64: 0x0000 msip; 0x4000 mtimecmp; 0xBFF8 mtime. Any other offset is unmapped.
REQ-020 Writes SHALL update only the byte lanes whose SEL_I bit is 1. For msip, only bit 0 is stored, and only when SEL_I[0]=1.
REQ-021 Unmapped offsets SHALL read 0, SHALL ignore writes, and SHALL still be acknowledged; no bus error exists.
REQ-022 A 7-bit-or-wider prescaler counter SHALL count 0..CLOCK_CYCLES-1 and then wrap to 0. mtime SHALL increment by 1 on each wrap. With CLOCK_CYCLES=1, mtime increments every cycle.
REQ-023 mtime SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-024 A write to mtime or to one of its halves in the same cycle as an increment:
- The write SHALL win.
- Unwritten bytes keep their pre-edge value, with no increment applied.
- The increment is lost.
- The prescaler continues counting unaffected.
REQ-025 In 32-bit mode, there SHALL be no carry or snapshot between the halves. A read of mtime[63:32] returns the live value at the sampling edge.
REQ-026 Reads of mtime SHALL return the value before any increment on the sampling edge.
REQ-027 mtime, mtimecmp and msip outputs SHALL be direct register outputs, with no combinational path from the bus inputs.
REQ-028 If CYC_I or STB_I drops while in ACK, the FSM SHALL still return to IDLE, and any write already performed SHALL remain.

Reset
REQ-029 While reset=1, regardless of clock:
- the FSM SHALL be in IDLE with ACK_O=0 and DAT_O=0;
- msip=0, mtime=0 and the prescaler=0;
- mtimecmp=0xFFFF_FFFF_FFFF_FFFF, so no timer interrupt is pending out of reset.
REQ-030 Reset asserted in the middle of an access SHALL abort it. ACK_O=0 immediately. Once reset is released, the block SHALL first accept a strobe on the first rising edge with reset=0, and no ACK is owed for the aborted access.

Verification
REQ-031 Bench scenario, reset and count: with CLOCK_CYCLES=4, release reset and wait 12 cycles -> mtime=3 and mtimecmp=all ones; ACK_O stays 0 throughout.
REQ-032 Bench scenario, msip write and read: write msip=0xFFFF_FFFF with SEL_I all ones -> ACK_O high 1 cycle after the strobe; msip=1; a read of 0x0000 returns 0x0000_0001.
REQ-033 Bench scenario, byte-lane write (DATA_SIZE=32): write 0x4000 with DAT_I=0xAABBCCDD and SEL_I=0b0010 -> mtimecmp[63:0]=0xFFFF_FFFF_FFFF_CCFF.
REQ-034 Bench scenario, write/increment collision: with CLOCK_CYCLES=1, write mtime low=0x10 -> next cycle mtime=0x10 and the cycle after that 0x11 (no 0x11 skip to 0x12).
REQ-035 Bench scenario, wrap and unmapped access: write mtime=0xFFFF_FFFF_FFFF_FFFF (64-bit) -> mtime reads 0 one increment later; a read of 0x1234 returns 0 with a single-cycle ACK.
REQ-036 Bench scenario, reset mid-access: assert reset during the ACK state -> ACK_O=0 asynchronously; mtimecmp returns to all ones; after release, a read of 0xBFF8 acks normally.

Source files
------------

// File: rtl/clint.sv
// Core-local interruptor: Wishbone slave exposing msip, mtimecmp and a
// free-running mtime counter advanced by a programmable prescaler.
module clint #(
    parameter int DATA_SIZE    = 32,
    parameter int CLOCK_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   CYC_I,
    input  logic                   STB_I,
    input  logic                   WE_I,
    input  logic [15:0]            ADR_I,
    input  logic [DATA_SIZE/8-1:0] SEL_I,
    input  logic [DATA_SIZE-1:0]   DAT_I,
    output logic [DATA_SIZE-1:0]   DAT_O,
    output logic                   ACK_O,
    output logic [DATA_SIZE-1:0]   msip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
);

    localparam int LANES = DATA_SIZE / 8;
    localparam int PW    = ($clog2(CLOCK_CYCLES) > 7) ? $clog2(CLOCK_CYCLES) : 7;

    // state | meaning
    // IDLE  | waiting for CYC_I & STB_I; access is sampled on the leaving edge
    // ACK   | acknowledge the access for one cycle
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic                   wr;
    logic                   hit_msip;
    logic                   hit_cmp_lo;
    logic                   hit_cmp_hi;
    logic                   hit_time_lo;
    logic                   hit_time_hi;
    logic                   tick;
    logic [PW-1:0]          presc;
    logic                   msip_bit;
    logic [DATA_SIZE-1:0]   rdata;

    // Replace the selected byte lanes of a 64-bit register; hi picks the
    // upper 32-bit half when the bus is 32 bits wide.
    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [DATA_SIZE-1:0] d,
                                          input logic [LANES-1:0] s,
                                          input logic hi);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < LANES; i++) begin
            if (s[i]) r[(hi ? 32 : 0) + 8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    assign accept = (state == IDLE) && CYC_I && STB_I;
    assign wr     = accept && WE_I;
    assign ACK_O  = (state == ACK);
    assign tick   = (presc == PW'(CLOCK_CYCLES - 1));
    assign msip   = DATA_SIZE'(msip_bit);

    // Bus FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Bus FSM next state: one ACK cycle per accepted strobe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (CYC_I && STB_I) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address decode; upper-half registers only exist on a 32-bit bus.
    always_comb begin
        hit_msip    = (ADR_I == 16'h0000);
        hit_cmp_lo  = (ADR_I == 16'h4000);
        hit_cmp_hi  = (DATA_SIZE == 32) && (ADR_I == 16'h4004);
        hit_time_lo = (ADR_I == 16'hBFF8);
        hit_time_hi = (DATA_SIZE == 32) && (ADR_I == 16'hBFFC);
    end

    // Read mux; the cast keeps the low DATA_SIZE bits of 64-bit registers.
    always_comb begin
        rdata = '0;
        if (hit_msip)         rdata = DATA_SIZE'(msip_bit);
        else if (hit_cmp_lo)  rdata = DATA_SIZE'(mtimecmp);
        else if (hit_cmp_hi)  rdata = DATA_SIZE'(mtimecmp[63:32]);
        else if (hit_time_lo) rdata = DATA_SIZE'(mtime);
        else if (hit_time_hi) rdata = DATA_SIZE'(mtime[63:32]);
    end

    // Prescaler runs 0..CLOCK_CYCLES-1 independently of bus writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // mtime: a bus write wins over the increment and drops it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mtime <= '0;
        else if (wr && (hit_time_lo || hit_time_hi))
            mtime <= merge(mtime, DAT_I, SEL_I, hit_time_hi);
        else if (tick)
            mtime <= mtime + 64'd1;
    end

    // mtimecmp resets to all ones so no timer interrupt is pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mtimecmp <= '1;
        else if (wr && (hit_cmp_lo || hit_cmp_hi))
            mtimecmp <= merge(mtimecmp, DAT_I, SEL_I, hit_cmp_hi);
    end

    // msip keeps only bit 0, written through lane 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         msip_bit <= 1'b0;
        else if (wr && hit_msip && SEL_I[0]) msip_bit <= DAT_I[0];
    end

    // Read data captured at acceptance and held until the next read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                DAT_O <= '0;
        else if (accept && !WE_I) DAT_O <= rdata;
    end

endmodule

// File: tb/tb_clint.sv
// Bench for clint: a 32-bit instance (prescale 1) and a 64-bit instance
// (prescale 4) compared against an arithmetic reference model.
module tb_clint;

    localparam int CC_A = 1;
    localparam int CC_B = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cyc_a, stb_a, cyc_b, stb_b, we;
    logic [15:0] adr;
    logic [7:0]  sel;
    logic [63:0] dat;

    logic [31:0] dat_o_a, msip_a;
    logic        ack_a;
    logic [63:0] mtime_a, cmp_a;
    logic [63:0] dat_o_b, msip_b, mtime_b, cmp_b;
    logic        ack_b;

    int vectors = 0;
    int fails   = 0;
    longint n;

    // model state, index 0 = 32-bit instance, 1 = 64-bit instance
    logic [63:0] m_base [2];
    longint      m_bn   [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];

    clint #(.DATA_SIZE(32), .CLOCK_CYCLES(CC_A)) u_a (
        .clock(clock), .reset(reset), .CYC_I(cyc_a), .STB_I(stb_a), .WE_I(we),
        .ADR_I(adr), .SEL_I(sel[3:0]), .DAT_I(dat[31:0]), .DAT_O(dat_o_a),
        .ACK_O(ack_a), .msip(msip_a), .mtime(mtime_a), .mtimecmp(cmp_a));

    clint #(.DATA_SIZE(64), .CLOCK_CYCLES(CC_B)) u_b (
        .clock(clock), .reset(reset), .CYC_I(cyc_b), .STB_I(stb_b), .WE_I(we),
        .ADR_I(adr), .SEL_I(sel), .DAT_I(dat), .DAT_O(dat_o_b),
        .ACK_O(ack_b), .msip(msip_b), .mtime(mtime_b), .mtimecmp(cmp_b));

    always #5 clock = ~clock;

    // count of rising edges seen since reset was released
    always @(posedge clock or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic int cc_of(input int b);
        return (b != 0) ? CC_B : CC_A;
    endfunction

    // mtime after nn edges: base value plus prescaler wraps since base was set
    function automatic logic [63:0] model_time(input int b, input longint nn);
        return m_base[b] + 64'(nn / cc_of(b) - m_bn[b] / cc_of(b));
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s, input int lanes, input int base);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < lanes; i++)
            if (s[i]) r[(base + i)*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_read(input int b, input logic [15:0] a, input longint e);
        logic [63:0] t;
        t = model_time(b, e);
        if (b == 0) begin
            case (a)
                16'h0000: return {63'b0, m_msip[0]};
                16'h4000: return {32'b0, m_cmp[0][31:0]};
                16'h4004: return {32'b0, m_cmp[0][63:32]};
                16'hBFF8: return {32'b0, t[31:0]};
                16'hBFFC: return {32'b0, t[63:32]};
                default:  return 64'd0;
            endcase
        end
        case (a)
            16'h0000: return {63'b0, m_msip[1]};
            16'h4000: return m_cmp[1];
            16'hBFF8: return t;
            default:  return 64'd0;
        endcase
    endfunction

    task automatic model_write(input int b, input logic [15:0] a, input logic [7:0] s,
                               input logic [63:0] d, input longint e);
        int lanes;
        lanes = (b == 0) ? 4 : 8;
        if (a == 16'h0000) begin
            if (s[0]) m_msip[b] = d[0];
        end else if (a == 16'h4000) begin
            m_cmp[b] = merge(m_cmp[b], d, s, lanes, 0);
        end else if (a == 16'hBFF8) begin
            m_base[b] = merge(model_time(b, e), d, s, lanes, 0);
            m_bn[b]   = e + 1;
        end else if (b == 0 && a == 16'h4004) begin
            m_cmp[b] = merge(m_cmp[b], d, s, lanes, 4);
        end else if (b == 0 && a == 16'hBFFC) begin
            m_base[b] = merge(model_time(b, e), d, s, lanes, 4);
            m_bn[b]   = e + 1;
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_base[b] = 64'd0;
            m_bn[b]   = 0;
            m_cmp[b]  = '1;
            m_msip[b] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int b);
        return (b != 0) ? ack_b : ack_a;
    endfunction

    function automatic logic [63:0] dato_of(input int b);
        return (b != 0) ? dat_o_b : {32'b0, dat_o_a};
    endfunction

    task automatic check_state(input int b);
        if (b == 0) begin
            chk("mtime_a", mtime_a, model_time(0, n));
            chk("mtimecmp_a", cmp_a, m_cmp[0]);
            chk("msip_a", {32'b0, msip_a}, {63'b0, m_msip[0]});
        end else begin
            chk("mtime_b", mtime_b, model_time(1, n));
            chk("mtimecmp_b", cmp_b, m_cmp[1]);
            chk("msip_b", msip_b, {63'b0, m_msip[1]});
        end
    endtask

    task automatic set_strobe(input int b, input logic c, input logic s);
        if (b != 0) begin cyc_b = c; stb_b = s; end
        else        begin cyc_a = c; stb_a = s; end
    endtask

    // one complete access: strobe, check the single ACK cycle and read data
    task automatic access(input int b, input bit w, input logic [15:0] a,
                          input logic [7:0] s, input logic [63:0] d);
        logic [63:0] exp_rd;
        longint e;
        @(negedge clock);
        we = w; adr = a; sel = s; dat = d;
        set_strobe(b, 1'b1, 1'b1);
        e = n;
        exp_rd = model_read(b, a, e);
        @(posedge clock); #1;
        set_strobe(b, 1'b0, 1'b0);
        if (w) model_write(b, a, s, d, e);
        chk("ack_rise", {63'b0, ack_of(b)}, 64'd1);
        chk("ack_other", {63'b0, ack_of(1 - b)}, 64'd0);
        if (!w) chk("rdata", dato_of(b), exp_rd);
        check_state(b);
        @(posedge clock); #1;
        chk("ack_fall", {63'b0, ack_of(b)}, 64'd0);
        if (!w) chk("rdata_hold", dato_of(b), exp_rd);
        check_state(b);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rs;
        logic [63:0] rd;
        int          rb;

        reset = 1'b1;
        cyc_a = 0; stb_a = 0; cyc_b = 0; stb_b = 0;
        we = 0; adr = '0; sel = '0; dat = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        for (int b = 0; b < 2; b++) begin
            chk("rst_ack", {63'b0, ack_of(b)}, 64'd0);
            chk("rst_dat", dato_of(b), 64'd0);
            check_state(b);
        end

        // release reset and let the timers run
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            chk("idle_ack_a", {63'b0, ack_a}, 64'd0);
            chk("idle_ack_b", {63'b0, ack_b}, 64'd0);
            chk("run_mtime_b", mtime_b, model_time(1, n));
        end
        chk("count_b", mtime_b, 64'd3);
        chk("count_cmp_b", cmp_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("count_a", mtime_a, 64'd12);

        // msip write and read back
        access(0, 1, 16'h0000, 8'h0F, 64'hFFFF_FFFF);
        chk("msip_set_a", {32'b0, msip_a}, 64'd1);
        access(0, 0, 16'h0000, 8'h0F, 64'd0);
        chk("msip_read_a", {32'b0, dat_o_a}, 64'd1);
        access(1, 1, 16'h0000, 8'hFF, '1);
        access(1, 0, 16'h0000, 8'hFF, 64'd0);

        // byte-lane write into mtimecmp low word
        access(0, 1, 16'h4000, 8'b0000_0010, 64'hAABB_CCDD);
        chk("lane_cmp_a", cmp_a, 64'hFFFF_FFFF_FFFF_CCFF);

        // write colliding with an increment every cycle
        access(0, 1, 16'hBFF8, 8'h0F, 64'h10);
        chk("collide_next", mtime_a, 64'h11);
        access(0, 0, 16'hBFFC, 8'h0F, 64'd0);

        // 64-bit wrap, then unmapped accesses
        access(1, 1, 16'hBFF8, 8'hFF, '1);
        for (int i = 0; i < 8 && mtime_b === 64'hFFFF_FFFF_FFFF_FFFF; i++) begin
            @(posedge clock); #1;
        end
        chk("wrap_zero", mtime_b, 64'd0);
        access(1, 0, 16'hBFF8, 8'hFF, 64'd0);
        access(1, 0, 16'h1234, 8'hFF, 64'd0);
        chk("unmapped_rd", dat_o_b, 64'd0);
        access(1, 1, 16'h1234, 8'hFF, 64'h0123_4567_89AB_CDEF);
        access(0, 1, 16'h1234, 8'h0F, 64'h0123_4567);

        // randomized accesses with idle gaps (some with CYC_I but no STB_I)
        for (int k = 0; k < 60; k++) begin
            rb = int'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0: ra = 16'h0000;
                1: ra = 16'h4000;
                2: ra = 16'h4004;
                3: ra = 16'hBFF8;
                4: ra = 16'hBFFC;
                5: ra = 16'(($urandom & 32'hFFFC));
                default: ra = 16'h1234;
            endcase
            rs = 8'($urandom);
            if (rb == 0) rs[7:4] = 4'h0;
            if (rs == 8'h00) rs = 8'h01;
            rd = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rd = '1;
            access(rb, 1'($urandom_range(0, 1)), ra, rs, rd);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                set_strobe(rb, 1'b1, 1'b0);
                @(posedge clock); #1;
                chk("no_stb_ack", {63'b0, ack_of(rb)}, 64'd0);
                set_strobe(rb, 1'b0, 1'b0);
            end
        end

        // reset in the middle of an access
        @(negedge clock);
        we = 1; adr = 16'h4000; sel = 8'hFF; dat = 64'd0;
        cyc_b = 1; stb_b = 1;
        @(posedge clock); #1;
        chk("pre_rst_ack", {63'b0, ack_b}, 64'd1);
        chk("pre_rst_cmp", cmp_b, 64'd0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_ack", {63'b0, ack_b}, 64'd0);
        chk("rst_async_cmp", cmp_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_async_mtime", mtime_b, 64'd0);
        cyc_b = 0; stb_b = 0; we = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        adr = 16'hBFF8; sel = 8'hFF;
        cyc_b = 1; stb_b = 1;
        @(posedge clock); #1;
        cyc_b = 0; stb_b = 0;
        chk("post_rst_ack", {63'b0, ack_b}, 64'd1);
        chk("post_rst_rd", dat_o_b, 64'd0);
        @(posedge clock); #1;
        chk("post_rst_ack_fall", {63'b0, ack_b}, 64'd0);
        check_state(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
